// File: rtl/uart_program_loader_pkg.sv
// Shared types and helpers for the UART program loader and its receiver core.
package uart_program_loader_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Width of a down-counter that must hold CLKS_PER_BIT-1.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Program-memory write port driven by the loader (master) into CPU memory (slave).
interface uart_program_loader_if #(
    parameter int WORD_WIDTH           = 7,
    parameter int MEMORY_ADDRESS_WIDTH = 4
);
    logic                            mem_we_o;
    logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [WORD_WIDTH-1:0]           mem_data_o;

    modport master (output mem_we_o, output mem_addr_o, output mem_data_o);
    modport slave  (input  mem_we_o, input  mem_addr_o, input  mem_data_o);
endinterface

// File: rtl/uart_program_loader_uart_rx_core.sv
// 8N1 UART receiver: rx synchroniser, mid-bit sampling FSM, one-cycle byte/error strobes.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a low level while enabled
// RX_START | half-bit wait, then confirm start bit (high = glitch, drop)
// RX_DATA  | sample 8 data bits LSB first, one per bit period
// RX_STOP  | sample stop bit; high = byte_valid, low = frame_err
module uart_rx_core
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      rx,
    output logic                      byte_valid,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      frame_err
);

    localparam int CW = baud_cnt_width(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_s;
    rx_state_t                 state;
    rx_state_t                 state_next;
    logic [CW-1:0]             baud_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      tick;

    assign tick      = (baud_cnt == '0);
    assign byte_data = shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE:  if (!rx_s) state_next = RX_START;
                RX_START: if (tick) state_next = rx_s ? RX_IDLE : RX_DATA;
                RX_DATA:  if (tick && bit_cnt == LAST_BIT) state_next = RX_STOP;
                RX_STOP:  if (tick) state_next = RX_IDLE;
                default:  state_next = RX_IDLE;
            endcase
        end
    end

    // Baud counter reloads with a half period in IDLE so the START check lands mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (state == RX_IDLE) begin
            baud_cnt <= HALF_RELOAD;
            bit_cnt  <= '0;
        end else if (tick) begin
            baud_cnt <= FULL_RELOAD;
            if (state == RX_DATA) begin
                shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            baud_cnt <= baud_cnt - 1'b1;
        end
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (en && state == RX_STOP && tick) begin
            byte_valid = rx_s;
            frame_err  = !rx_s;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// UART bootloader: holds the CPU while programming, writes received words
// sequentially into program memory, then verifies a trailing XOR checksum byte.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT         = 16,
    parameter int WORD_WIDTH           = 7,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  bl_programm_i,
    input  logic                  rx_i,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  error_o,
    uart_program_loader_if.master mem
);

    // One extra bit so the count can reach MEMORY_REGISTERS itself.
    localparam int CNT_W = MEMORY_ADDRESS_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MEMORY_REGISTERS);

    logic                      prog_meta;
    logic                      prog_s;
    logic                      prog_rise;
    logic                      byte_valid;
    logic                      frame_err;
    logic [UART_DATA_BITS-1:0] byte_data;
    logic [CNT_W-1:0]          count;
    logic                      locked;
    logic [UART_DATA_BITS-1:0] checksum;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prog_meta  <= 1'b0;
            prog_s     <= 1'b0;
            cpu_hold_o <= 1'b0;
        end else begin
            prog_meta  <= bl_programm_i;
            prog_s     <= prog_meta;
            cpu_hold_o <= prog_s;
        end
    end

    // cpu_hold_o is prog_s delayed by one cycle, so it doubles as the edge-detect history.
    assign prog_rise = prog_s & ~cpu_hold_o;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk_i),
        .rst        (reset_i),
        .en         (prog_s),
        .rx         (rx_i),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count          <= '0;
            locked         <= 1'b0;
            checksum       <= '0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            mem.mem_we_o   <= 1'b0;
            mem.mem_addr_o <= '0;
            mem.mem_data_o <= '0;
        end else begin
            mem.mem_we_o <= 1'b0;
            if (prog_rise) begin
                count    <= '0;
                locked   <= 1'b0;
                checksum <= '0;
                done_o   <= 1'b0;
                error_o  <= 1'b0;
            end else if (!locked) begin
                if (frame_err) begin
                    error_o <= 1'b1;
                end
                if (byte_valid) begin
                    if (count < LAST_COUNT) begin
                        mem.mem_we_o   <= 1'b1;
                        mem.mem_addr_o <= count[MEMORY_ADDRESS_WIDTH-1:0];
                        mem.mem_data_o <= byte_data[WORD_WIDTH-1:0];
                        checksum       <= checksum ^ byte_data;
                        count          <= count + 1'b1;
                    end else begin
                        locked <= 1'b1;
                        if (byte_data == checksum) begin
                            done_o <= 1'b1;
                        end else begin
                            error_o <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
